// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Bundles every signal of the instruction-fetch stage except clock and reset.
//
//   Pipeline control (into the stage):
//     stall[3:0]          pipeline stall vector, stage advances only on 4'b0000
//     exception           pipeline flush, redirect fetch to exception_pc
//     exception_pc[31:0]  exception handler address
//     branch_flag         ID-stage branch taken, held until IF advances
//     branch_target[31:0] taken-branch target
//   Instruction memory (sram-like):
//     inst_req / inst_addr[31:0]       request from the stage
//     inst_addr_ok / inst_data_ok      request accepted / read data valid
//     inst_rdata[31:0]                 read data
//   Towards IF/ID:
//     if_pc[31:0], if_instr[31:0], if_exception_type[5:0], stallreq_if
//
// Modports: master = the fetch stage, slave = pipeline + memory around it.
// -----------------------------------------------------------------------------
interface if_stage_if;
    logic [3:0]  stall;
    logic        exception;
    logic [31:0] exception_pc;
    logic        branch_flag;
    logic [31:0] branch_target;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [5:0]  if_exception_type;
    logic        stallreq_if;

    modport master (
        input  stall, exception, exception_pc, branch_flag, branch_target,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output inst_req, inst_addr,
        output if_pc, if_instr, if_exception_type, stallreq_if
    );

    modport slave (
        output stall, exception, exception_pc, branch_flag, branch_target,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  inst_req, inst_addr,
        input  if_pc, if_instr, if_exception_type, stallreq_if
    );
endinterface

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage with a single-outstanding sram-like instruction
// memory port. Fetches the word at pc, holds it for IF/ID until the pipeline
// advances, then moves pc to pc+4 or to a taken branch target. An exception
// redirects pc immediately; a read already in flight is drained and dropped.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (pc = 32'hBFC00000)
//   bus  if_stage_if.master, pipeline control, memory port and IF/ID outputs
// -----------------------------------------------------------------------------
module if_stage (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  bus
);

    typedef enum logic [1:0] {
        S_REQ       = 2'd0,
        S_WAIT_DATA = 2'd1,
        S_HOLD      = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_discard;
    logic [31:0] r_ibuf;

    logic        w_misaligned;
    logic        w_advance;

    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign w_advance    = (bus.stall == 4'b0000);

    // Outputs are decoded from registered state only, so the memory handshake
    // inputs never feed back combinationally into inst_req. The reset gating
    // keeps the outputs quiet during the cycles rst is asserted, before the
    // synchronous reset has taken effect on the state registers.
    assign bus.inst_req          = !rst && (r_state == S_REQ) && !w_misaligned;
    assign bus.inst_addr         = r_pc;
    assign bus.if_pc             = r_pc;
    assign bus.if_instr          = (!rst && (r_state == S_HOLD)) ? r_ibuf : 32'h0;
    assign bus.stallreq_if       = rst || (r_state != S_HOLD);
    assign bus.if_exception_type = {5'b00000, (!rst && w_misaligned)};

    // Fetch state machine.
    // REQ:       issue the request (aligned pc) or fake a nop fetch (misaligned
    //            pc, flagged as AdEL through if_exception_type).
    // WAIT_DATA: exactly one read in flight; discard marks a read that was
    //            overtaken by an exception and must be thrown away.
    // HOLD:      instruction is presented until the pipeline advances. The
    //            word held while branch_flag is set is the delay slot, so the
    //            redirect happens on the same edge it is consumed.
    // An exception always wins over stall and branch, but the bus protocol
    // still forces us to wait for any read that is (or just became) in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_state   <= S_REQ;
            r_discard <= 1'b0;
            r_ibuf    <= 32'h0;
        end else if (bus.exception) begin
            r_pc <= bus.exception_pc;
            case (r_state)
                S_REQ: begin
                    if (!w_misaligned && bus.inst_addr_ok) begin
                        r_state   <= S_WAIT_DATA;
                        r_discard <= 1'b1;
                    end else begin
                        r_state   <= S_REQ;
                    end
                end
                S_WAIT_DATA: begin
                    if (bus.inst_data_ok) begin
                        r_state   <= S_REQ;
                        r_discard <= 1'b0;
                    end else begin
                        r_discard <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_REQ;
                    r_discard <= 1'b0;
                end
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_misaligned) begin
                        r_state <= S_HOLD;
                        r_ibuf  <= 32'h0;
                    end else if (bus.inst_addr_ok) begin
                        r_state <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (bus.inst_data_ok) begin
                        if (r_discard) begin
                            r_discard <= 1'b0;
                            r_state   <= S_REQ;
                        end else begin
                            r_ibuf    <= bus.inst_rdata;
                            r_state   <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_advance) begin
                        r_pc    <= bus.branch_flag ? bus.branch_target : (r_pc + 32'd4);
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state   <= S_REQ;
                    r_discard <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed scenarios for reset, fetch latency, stall, branch, exception
// flushing, misaligned targets and pc wrap, followed by a randomized run with
// a modelled memory (random accept/data latency) and random stall, branch and
// exception traffic. The reference tracks only the architectural pc sequence
// and the word the memory holds at each address.
// -----------------------------------------------------------------------------
module tb_if_stage;

    logic clk;
    logic rst;

    if_stage_if bus ();

    if_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checkCount;
    int passCount;

    // Free-running clock, outputs are sampled and inputs driven on negedge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Contents of the modelled instruction memory.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h13579BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] stall, input logic branchFlag,
                                 input logic [31:0] branchTarget, input logic exc,
                                 input logic [31:0] excPc);
        bus.stall         = stall;
        bus.branch_flag   = branchFlag;
        bus.branch_target = branchTarget;
        bus.exception     = exc;
        bus.exception_pc  = excPc;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // From a REQ cycle: accept now, deliver data next cycle, end in HOLD.
    task automatic fetchToHold(input logic [31:0] word);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = word;
        tick();
        bus.inst_data_ok = 1'b0;
    endtask

    initial begin
        logic [31:0] expPc;
        logic        outstanding;
        int          waitCycles;
        logic [31:0] pendAddr;
        logic        inHold;
        logic [31:0] expInstr;

        checkCount = 0;
        passCount  = 0;
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;

        // Reset, with a stray exception and memory responses that must be ignored
        bus.exception    = 1'b1;
        bus.exception_pc = 32'h12345678;
        bus.inst_data_ok = 1'b1;
        tick();
        bus.exception    = 1'b0;
        bus.inst_data_ok = 1'b0;
        tick();
        checkOutput("rst_pc", bus.if_pc, 32'hBFC00000);
        checkOutput("rst_inst_req", {31'b0, bus.inst_req}, 32'h0);
        checkOutput("rst_stallreq", {31'b0, bus.stallreq_if}, 32'h1);
        checkOutput("rst_instr", bus.if_instr, 32'h0);
        checkOutput("rst_exc_type", {26'b0, bus.if_exception_type}, 32'h0);

        // Release reset, minimum-latency fetch
        rst = 1'b0;
        bus.inst_addr_ok = 1'b1;
        #1;
        checkOutput("first_req", {31'b0, bus.inst_req}, 32'h1);
        checkOutput("first_addr", bus.inst_addr, 32'hBFC00000);
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h24010001;
        checkOutput("wait_no_req", {31'b0, bus.inst_req}, 32'h0);
        checkOutput("wait_stallreq", {31'b0, bus.stallreq_if}, 32'h1);
        tick();
        bus.inst_data_ok = 1'b0;
        checkOutput("hold_stallreq", {31'b0, bus.stallreq_if}, 32'h0);
        checkOutput("hold_pc", bus.if_pc, 32'hBFC00000);
        checkOutput("hold_instr", bus.if_instr, 32'h24010001);
        tick();
        checkOutput("seq_addr", bus.inst_addr, 32'hBFC00004);
        checkOutput("seq_req", {31'b0, bus.inst_req}, 32'h1);

        // Stall in HOLD for three cycles
        fetchToHold(32'h8C220004);
        applyStimulus(4'b0010, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_pc", bus.if_pc, 32'hBFC00004);
            checkOutput("stall_instr", bus.if_instr, 32'h8C220004);
            checkOutput("stall_no_req", {31'b0, bus.inst_req}, 32'h0);
        end
        applyStimulus(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checkOutput("after_stall_addr", bus.inst_addr, 32'hBFC00008);

        // Taken branch from HOLD
        fetchToHold(32'h10000040);
        applyStimulus(4'b0000, 1'b1, 32'hBFC00100, 1'b0, 32'h0);
        tick();
        applyStimulus(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("branch_addr", bus.inst_addr, 32'hBFC00100);

        // Exception while a read is in flight, data arrives two cycles later
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        applyStimulus(4'b0000, 1'b0, 32'h0, 1'b1, 32'hBFC00380);
        tick();
        applyStimulus(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("exc_pc", bus.if_pc, 32'hBFC00380);
        checkOutput("exc_wait_no_req", {31'b0, bus.inst_req}, 32'h0);
        tick();
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hDEADBEEF;
        checkOutput("exc_instr_a", bus.if_instr, 32'h0);
        tick();
        bus.inst_data_ok = 1'b0;
        checkOutput("exc_instr_b", bus.if_instr, 32'h0);
        checkOutput("exc_req", {31'b0, bus.inst_req}, 32'h1);
        checkOutput("exc_addr", bus.inst_addr, 32'hBFC00380);

        // addr_ok held low for five cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("backpressure_req", {31'b0, bus.inst_req}, 32'h1);
            checkOutput("backpressure_addr", bus.inst_addr, 32'hBFC00380);
            checkOutput("backpressure_stallreq", {31'b0, bus.stallreq_if}, 32'h1);
        end
        fetchToHold(32'h00000013);
        checkOutput("handler_instr", bus.if_instr, 32'h00000013);

        // Misaligned branch target, AdEL without a memory request
        applyStimulus(4'b0000, 1'b1, 32'hBFC00102, 1'b0, 32'h0);
        tick();
        applyStimulus(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("adel_no_req", {31'b0, bus.inst_req}, 32'h0);
        tick();
        checkOutput("adel_stallreq", {31'b0, bus.stallreq_if}, 32'h0);
        checkOutput("adel_pc", bus.if_pc, 32'hBFC00102);
        checkOutput("adel_instr", bus.if_instr, 32'h0);
        checkOutput("adel_type", {26'b0, bus.if_exception_type}, 32'h01);

        // Exception overrides stall in HOLD
        applyStimulus(4'b1111, 1'b1, 32'hBFC00200, 1'b1, 32'hBFC00400);
        tick();
        applyStimulus(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("exc_hold_addr", bus.inst_addr, 32'hBFC00400);
        checkOutput("exc_hold_type", {26'b0, bus.if_exception_type}, 32'h0);

        // Exception in the same cycle the request is accepted
        bus.inst_addr_ok = 1'b1;
        applyStimulus(4'b0000, 1'b0, 32'h0, 1'b1, 32'hBFC00500);
        tick();
        bus.inst_addr_ok = 1'b0;
        applyStimulus(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("exc_accept_no_req", {31'b0, bus.inst_req}, 32'h0);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hCAFEBABE;
        tick();
        bus.inst_data_ok = 1'b0;
        checkOutput("exc_accept_addr", bus.inst_addr, 32'hBFC00500);
        checkOutput("exc_accept_instr", bus.if_instr, 32'h0);

        // pc wraps from FFFFFFFC to 0
        fetchToHold(32'h11111111);
        applyStimulus(4'b0000, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0);
        tick();
        applyStimulus(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("top_addr", bus.inst_addr, 32'hFFFFFFFC);
        fetchToHold(32'h22222222);
        checkOutput("top_pc", bus.if_pc, 32'hFFFFFFFC);
        tick();
        checkOutput("wrap_addr", bus.inst_addr, 32'h00000000);

        // Randomized traffic against the pc-sequence model
        expPc       = 32'h0;
        outstanding = 1'b0;
        waitCycles  = 0;
        pendAddr    = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            inHold   = !bus.stallreq_if;
            expInstr = (expPc[1:0] != 2'b00) ? 32'h0 : memWord(expPc);
            checkOutput("rnd_pc", bus.if_pc, expPc);
            checkOutput("rnd_type", {26'b0, bus.if_exception_type},
                        {31'b0, (expPc[1:0] != 2'b00)});
            if (inHold) begin
                checkOutput("rnd_instr", bus.if_instr, expInstr);
            end else begin
                checkOutput("rnd_nop", bus.if_instr, 32'h0);
            end
            if (outstanding || expPc[1:0] != 2'b00) begin
                checkOutput("rnd_no_req", {31'b0, bus.inst_req}, 32'h0);
            end
            if (bus.inst_req) begin
                checkOutput("rnd_addr", bus.inst_addr, expPc);
            end

            // Memory responder: accept with random delay, then one data beat
            bus.inst_addr_ok = 1'b0;
            bus.inst_data_ok = 1'b0;
            bus.inst_rdata   = $urandom;
            if (outstanding) begin
                if (waitCycles == 0) begin
                    bus.inst_data_ok = 1'b1;
                    bus.inst_rdata   = memWord(pendAddr);
                    outstanding      = 1'b0;
                end else begin
                    waitCycles--;
                end
            end else if (bus.inst_req && ($urandom_range(0, 2) != 0)) begin
                bus.inst_addr_ok = 1'b1;
                pendAddr         = bus.inst_addr;
                outstanding      = 1'b1;
                waitCycles       = $urandom_range(0, 2);
            end

            // Pipeline side
            bus.stall         = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            bus.branch_flag   = inHold && ($urandom_range(0, 2) == 0);
            bus.branch_target = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFFFFFC);
            bus.exception     = ($urandom_range(0, 39) == 0);
            bus.exception_pc  = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFFFFFC);

            if (bus.exception) begin
                expPc = bus.exception_pc;
            end else if (inHold && bus.stall == 4'b0000) begin
                expPc = bus.branch_flag ? bus.branch_target : expPc + 32'd4;
            end
            tick();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
